// File: rtl/comptr_if.sv
// Request/result bundle for the chunk-serial comparator.
// master drives operands and start; slave returns status and flags.
interface comptr_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             signedMode;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic             brGtr;
  logic             brLte;
  logic             brEq;

  modport master (
    output start,
    output signedMode,
    output in1,
    output in2,
    input  busy,
    input  done,
    input  brGtr,
    input  brLte,
    input  brEq
  );

  modport slave (
    input  start,
    input  signedMode,
    input  in1,
    input  in2,
    output busy,
    output done,
    output brGtr,
    output brLte,
    output brEq
  );

endinterface

// File: rtl/comptr_seq.sv
// Chunk-serial magnitude comparator: walks CHUNK-bit slices from the MSB end
// and stops at the first difference, giving signed or unsigned gt/lt/eq flags.
module comptr_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic     clk,
  input logic     rst,
  comptr_if.slave bus
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDXW-1:0]  TOP_IDX  = IDXW'(N - 1);
  localparam logic [IDXW-1:0]  ZERO_IDX = '0;
  localparam logic [IDXW-1:0]  ONE_IDX  = IDXW'(1);
  localparam logic [CHUNK-1:0] MSB_MASK = ~({CHUNK{1'b1}} >> 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_r;
  logic [IDXW-1:0]  idx_r;
  logic [WIDTH-1:0] opA_r;
  logic [WIDTH-1:0] opB_r;
  logic             sgn_r;
  logic             gtr_r;
  logic             lte_r;
  logic             eq_r;

  logic [1:0]       stateNext_s;
  logic [IDXW-1:0]  idxNext_s;
  logic [WIDTH-1:0] opANext_s;
  logic [WIDTH-1:0] opBNext_s;
  logic             sgnNext_s;
  logic             gtrNext_s;
  logic             lteNext_s;
  logic             eqNext_s;

  logic             accept_s;
  logic [WIDTH-1:0] shiftA_s;
  logic [WIDTH-1:0] shiftB_s;
  logic [CHUNK-1:0] chunkA_s;
  logic [CHUNK-1:0] chunkB_s;
  logic             chunkGt_s;
  logic             chunkLt_s;

  // Unsigned chunk compare, returned as {greater, less}.
  function automatic logic [1:0] cmpChunk(input logic [CHUNK-1:0] x,
                                          input logic [CHUNK-1:0] y);
    logic [1:0] res;
    if (x > y) begin
      res = 2'b10;
    end else if (x < y) begin
      res = 2'b01;
    end else begin
      res = 2'b00;
    end
    return res;
  endfunction

  // A new compare may only be taken when no compare is in flight.
  always_comb begin
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: accept_s = bus.start;
      ST_DONE: accept_s = bus.start;
      ST_CMP:  accept_s = 1'b0;
      default: accept_s = 1'b0;
    endcase
  end

  // Select the current chunk; the top chunk gets its sign bit flipped in
  // signed mode so that an unsigned compare orders two's-complement values.
  always_comb begin
    shiftA_s = opA_r >> (int'(idx_r) * CHUNK);
    shiftB_s = opB_r >> (int'(idx_r) * CHUNK);
    if (sgn_r && (idx_r == TOP_IDX)) begin
      chunkA_s = shiftA_s[CHUNK-1:0] ^ MSB_MASK;
      chunkB_s = shiftB_s[CHUNK-1:0] ^ MSB_MASK;
    end else begin
      chunkA_s = shiftA_s[CHUNK-1:0];
      chunkB_s = shiftB_s[CHUNK-1:0];
    end
    {chunkGt_s, chunkLt_s} = cmpChunk(chunkA_s, chunkB_s);
  end

  // Next-state and datapath update.
  always_comb begin
    stateNext_s = state_r;
    idxNext_s   = idx_r;
    opANext_s   = opA_r;
    opBNext_s   = opB_r;
    sgnNext_s   = sgn_r;
    gtrNext_s   = gtr_r;
    lteNext_s   = lte_r;
    eqNext_s    = eq_r;

    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          stateNext_s = ST_CMP;
          idxNext_s   = TOP_IDX;
          opANext_s   = bus.in1;
          opBNext_s   = bus.in2;
          sgnNext_s   = bus.signedMode;
          gtrNext_s   = 1'b0;
          lteNext_s   = 1'b0;
          eqNext_s    = 1'b0;
        end else begin
          stateNext_s = ST_IDLE;
        end
      end
      ST_CMP: begin
        if (chunkGt_s) begin
          gtrNext_s   = 1'b1;
          stateNext_s = ST_DONE;
        end else if (chunkLt_s) begin
          lteNext_s   = 1'b1;
          stateNext_s = ST_DONE;
        end else if (idx_r == ZERO_IDX) begin
          eqNext_s    = 1'b1;
          stateNext_s = ST_DONE;
        end else begin
          idxNext_s   = idx_r - ONE_IDX;
        end
      end
      default: begin
        stateNext_s = ST_IDLE;
      end
    endcase
  end

  // State registers; reset wins over everything including a pending start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= TOP_IDX;
      opA_r   <= '0;
      opB_r   <= '0;
      sgn_r   <= 1'b0;
      gtr_r   <= 1'b0;
      lte_r   <= 1'b0;
      eq_r    <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      idx_r   <= idxNext_s;
      opA_r   <= opANext_s;
      opB_r   <= opBNext_s;
      sgn_r   <= sgnNext_s;
      gtr_r   <= gtrNext_s;
      lte_r   <= lteNext_s;
      eq_r    <= eqNext_s;
    end
  end

  assign bus.busy  = (state_r == ST_CMP);
  assign bus.done  = (state_r == ST_DONE);
  assign bus.brGtr = gtr_r;
  assign bus.brLte = lte_r;
  assign bus.brEq  = eq_r;

endmodule

// File: tb/tb_comptr_seq.sv
// Drives several comptr_seq configurations in parallel with shared stimulus and
// checks flags and latency against an arithmetic reference compare.
module tb_comptr_seq;

  localparam int NCFG   = 8;
  localparam int WAITCY = 24;

  function automatic int cfgW(input int i);
    case (i)
      0: return 16;
      1: return 8;
      2: return 8;
      3: return 32;
      4: return 32;
      5: return 16;
      6: return 32;
      7: return 16;
      default: return 16;
    endcase
  endfunction

  function automatic int cfgC(input int i);
    case (i)
      0: return 4;
      1: return 1;
      2: return 8;
      3: return 2;
      4: return 8;
      5: return 16;
      6: return 32;
      7: return 1;
      default: return 4;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        st;
  logic        sg;
  logic [31:0] a;
  logic [31:0] b;

  logic [NCFG-1:0] busyV, doneV, gV, lV, eV;

  int nCmp = 0;
  int nErr = 0;
  int lat0;
  logic [2:0] fl0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : gCfg
    localparam int W = cfgW(g);
    localparam int C = cfgC(g);
    comptr_if #(.WIDTH(W)) bus ();
    assign bus.start      = st;
    assign bus.signedMode = sg;
    assign bus.in1        = a[W-1:0];
    assign bus.in2        = b[W-1:0];
    assign busyV[g]       = bus.busy;
    assign doneV[g]       = bus.done;
    assign gV[g]          = bus.brGtr;
    assign lV[g]          = bus.brLte;
    assign eV[g]          = bus.brEq;
    comptr_seq #(.WIDTH(W), .CHUNK(C)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: value compare on sign/zero-extended integers; latency is the
  // 1-based position of the first differing chunk counted from the top.
  function automatic void refCmp(input logic [31:0] ia, input logic [31:0] ib,
                                 input logic isg, input int w, input int c,
                                 output int lat, output logic [2:0] fl);
    longint ma, mb, va, vb, cm;
    int n;
    ma = longint'({32'd0, ia}) & ((64'sd1 <<< w) - 64'sd1);
    mb = longint'({32'd0, ib}) & ((64'sd1 <<< w) - 64'sd1);
    va = ma;
    vb = mb;
    if (isg && ma[w-1]) va = ma - (64'sd1 <<< w);
    if (isg && mb[w-1]) vb = mb - (64'sd1 <<< w);
    if (va > vb)      fl = 3'b100;
    else if (va < vb) fl = 3'b010;
    else              fl = 3'b001;
    n   = w / c;
    cm  = (64'sd1 <<< c) - 64'sd1;
    lat = n;
    for (int i = n - 1; i >= 0; i--) begin
      if (((ma >> (i * c)) & cm) != ((mb >> (i * c)) & cm)) begin
        lat = n - i;
        break;
      end
    end
  endfunction

  task automatic runAll(input logic [31:0] ia, input logic [31:0] ib, input logic isg);
    int         lat[NCFG];
    logic [2:0] fl[NCFG];
    logic       seen[NCFG];
    int         viol;
    int         eLat;
    logic [2:0] eFl;
    viol = 0;
    for (int g = 0; g < NCFG; g++) begin
      lat[g]  = 0;
      fl[g]   = 3'b000;
      seen[g] = 1'b0;
    end
    st = 1'b1; a = ia; b = ib; sg = isg;
    tick();
    st = 1'b0;
    check("acceptBusy", 64'(busyV), 64'({NCFG{1'b1}}));
    check("acceptClear", 64'(gV | lV | eV), 64'd0);
    for (int cyc = 1; cyc <= WAITCY; cyc++) begin
      tick();
      for (int g = 0; g < NCFG; g++) begin
        if (busyV[g] && (doneV[g] || gV[g] || lV[g] || eV[g])) viol++;
        if (doneV[g] && seen[g]) begin
          viol++;
        end else if (doneV[g]) begin
          seen[g] = 1'b1;
          lat[g]  = cyc;
          fl[g]   = {gV[g], lV[g], eV[g]};
        end
      end
    end
    check("busyExclusive", 64'(viol), 64'd0);
    for (int g = 0; g < NCFG; g++) begin
      refCmp(ia, ib, isg, cfgW(g), cfgC(g), eLat, eFl);
      check($sformatf("lat[%0d]", g), 64'(lat[g]), 64'(eLat));
      check($sformatf("flags[%0d]", g), 64'(fl[g]), 64'(eFl));
      check($sformatf("held[%0d]", g), 64'({gV[g], lV[g], eV[g]}), 64'(eFl));
    end
    lat0 = lat[0];
    fl0  = fl[0];
  endtask

  task automatic dirCheck(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic isg, input int eLat, input logic [2:0] eFl);
    runAll(ia, ib, isg);
    check({tag, "_lat"}, 64'(lat0), 64'(eLat));
    check({tag, "_flags"}, 64'(fl0), 64'(eFl));
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          kind;
    rst = 1'b1; st = 1'b0; sg = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    check("rstBusy", 64'(busyV), 64'd0);
    check("rstDone", 64'(doneV), 64'd0);
    check("rstFlags", 64'(gV | lV | eV), 64'd0);
    rst = 1'b0;

    dirCheck("u8000", 32'h8000, 32'h7FFF, 1'b0, 1, 3'b100);
    dirCheck("s8000", 32'h8000, 32'h7FFF, 1'b1, 1, 3'b010);
    dirCheck("sFFFF", 32'hFFFF, 32'h0001, 1'b1, 1, 3'b010);
    dirCheck("eqU", 32'hA5A5, 32'hA5A5, 1'b0, 4, 3'b001);
    dirCheck("eqS", 32'hA5A5, 32'hA5A5, 1'b1, 4, 3'b001);
    dirCheck("lsb", 32'h1234, 32'h1235, 1'b0, 4, 3'b010);

    // Ignored start during CMP, then back-to-back restart from DONE.
    st = 1'b1; a = 32'h1234; b = 32'h1235; sg = 1'b0;
    tick();
    st = 1'b0;
    tick();
    check("b2bBusy1", 64'(busyV[0]), 64'd1);
    st = 1'b1; a = 32'hFFFF; b = 32'h0000;
    tick();
    st = 1'b0;
    check("ignBusy", 64'(busyV[0]), 64'd1);
    tick();
    check("ignNotDone", 64'(doneV[0]), 64'd0);
    tick();
    check("b2bDone1", 64'(doneV[0]), 64'd1);
    check("b2bFlags1", 64'({gV[0], lV[0], eV[0]}), 64'(3'b010));
    st = 1'b1; a = 32'h9000; b = 32'h1000;
    tick();
    st = 1'b0;
    check("b2bBusy2", 64'(busyV[0]), 64'd1);
    check("b2bNoDone", 64'(doneV[0]), 64'd0);
    check("b2bClear", 64'({gV[0], lV[0], eV[0]}), 64'd0);
    tick();
    check("b2bDone2", 64'(doneV[0]), 64'd1);
    check("b2bFlags2", 64'({gV[0], lV[0], eV[0]}), 64'(3'b100));

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Reset in the middle of an equal-operand compare.
    st = 1'b1; a = 32'hA5A5; b = 32'hA5A5; sg = 1'b0;
    tick();
    st = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midRstBusy", 64'(busyV), 64'd0);
    check("midRstDone", 64'(doneV), 64'd0);
    check("midRstFlags", 64'(gV | lV | eV), 64'd0);
    tick();
    check("midRstIdle", 64'(busyV | doneV), 64'd0);

    rst = 1'b1; st = 1'b1; a = 32'h0F00; b = 32'h0E00;
    tick();
    check("rstPriority", 64'(busyV), 64'd0);
    rst = 1'b0; st = 1'b0;
    dirCheck("postRst", 32'h0F00, 32'h0E00, 1'b0, 2, 3'b100);

    for (int it = 0; it < 150; it++) begin
      kind = int'($urandom_range(0, 3));
      ra   = $urandom;
      case (kind)
        0: rb = $urandom;
        1: rb = ra;
        2: rb = ra ^ (32'd1 << $urandom_range(0, 31));
        default: rb = ra ^ ($urandom & ((32'd1 << $urandom_range(0, 31)) - 32'd1));
      endcase
      runAll(ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
